// File: rtl/counter_param_if.sv
// counter_param_if
//   Groups the control inputs and status outputs of counter_param into one
//   bundle so that a parent block can hand the counter a single port.
//
//   Signals (WIDTH = counter width):
//     clr       1      synchronous clear to zero
//     load      1      synchronous load of load_val
//     load_val  WIDTH  value to load, clamped to MAX inside the counter
//     en        1      count enable
//     up_dn     1      1 = count up, 0 = count down
//     out       WIDTH  current count
//     tc        1      one-cycle terminal-count pulse
//     ovf       1      sticky overflow/underflow flag
//
//   Modports:
//     master  drives the controls and observes the status (parent / bench)
//     slave   the counter itself

interface counter_param_if #(
   parameter int WIDTH = 8
);

   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             up_dn;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             ovf;

   modport master (
      output clr, load, load_val, en, up_dn,
      input  out, tc, ovf
   );

   modport slave (
      input  clr, load, load_val, en, up_dn,
      output out, tc, ovf
   );

endinterface

// File: rtl/counter_param.sv
// counter_param
//   Parametrised up/down counter with synchronous clear and load, selectable
//   wrap or saturate behaviour at the limits, a registered terminal-count
//   pulse and a sticky overflow flag.
//
//   Parameters:
//     WIDTH     counter width in bits (2..32)
//     MAX       terminal value, count range is 0..MAX (1..2**WIDTH-1)
//     SATURATE  0 = wrap at the limits, 1 = hold at the limits
//
//   Ports:
//     clk    input   rising-edge clock
//     reset  input   asynchronous, active-low reset
//     bus    slave   counter_param_if carrying clr/load/load_val/en/up_dn
//                    in and out/tc/ovf out
//
//   Priority on each rising edge: clr > load > en > hold.
//   All three outputs come straight from flops.

module counter_param #(
   parameter int              WIDTH    = 8,
   parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
   parameter int              SATURATE = 0
) (
   input  logic           clk,
   input  logic           reset,
   counter_param_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_V  = MAX[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ZERO_V = '0;
   localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count;
   logic             tc_q;
   logic             ovf_q;

   logic [WIDTH-1:0] load_clamp;
   logic             at_max;
   logic             at_zero;

   // Limit detection and load clamping. Because the up step is only taken
   // below MAX and the down step only above zero, the +1/-1 below can never
   // rely on the natural WIDTH-bit wrap, so a MAX smaller than the full
   // range still wraps at MAX. A load above MAX is pulled back to MAX so the
   // count can never leave 0..MAX.
   always_comb begin
      at_max     = (count == MAX_V);
      at_zero    = (count == ZERO_V);
      load_clamp = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
   end

   // Count register with its pulse and sticky flags. A limit event is an
   // enabled step while sitting on the limit in the chosen direction: it
   // either wraps to the opposite limit or holds, and in both cases fires
   // tc and sets ovf. While saturated, every enabled cycle against the limit
   // is a fresh event, so tc stays high for as long as the push continues.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= ZERO_V;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (bus.clr) begin
         count <= ZERO_V;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (bus.load) begin
         count <= load_clamp;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (bus.en) begin
         if (bus.up_dn) begin
            if (at_max) begin
               count <= (SATURATE != 0) ? MAX_V : ZERO_V;
               tc_q  <= 1'b1;
               ovf_q <= 1'b1;
            end else begin
               count <= count + ONE_V;
               tc_q  <= 1'b0;
            end
         end else begin
            if (at_zero) begin
               count <= (SATURATE != 0) ? ZERO_V : MAX_V;
               tc_q  <= 1'b1;
               ovf_q <= 1'b1;
            end else begin
               count <= count - ONE_V;
               tc_q  <= 1'b0;
            end
         end
      end else begin
         tc_q <= 1'b0;
      end
   end

   // Outputs are the flops themselves, no logic after them.
   always_comb begin
      bus.out = count;
      bus.tc  = tc_q;
      bus.ovf = ovf_q;
   end

endmodule

// File: doc/counter_param.md
# counter_param

Parametrised up/down counter: next generation of the team's free-running clock counter, generalised in width and modulus, with direction control, synchronous load/clear, wrap-or-saturate mode, terminal-count pulse and sticky overflow flag. Used as a general timing/event counter inside larger blocks and as the standard DUT for the team's simulation bench flow (dump, clock, reset generators).

## Interface
- WIDTH, 8: counter width in bits; legal 2..32.
- MAX, 2**WIDTH-1: terminal value; count range is 0..MAX inclusive; legal 1..2**WIDTH-1.
- SATURATE, 0: 0 = wrap at limits, 1 = hold at limits.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- out  output  WIDTH  current count, registered.
- tc  output  1  one-cycle terminal-count pulse, registered.
- ovf  output  1  sticky overflow/underflow flag, registered.

## Operation
- Reset (reset=0): out=0, tc=0, ovf=0 immediately, independent of clk; held while reset low. First update on first rising clk edge after reset returns high.
- Per rising edge, priority clr > load > en > hold:
  - clr=1: out<=0, tc<=0, ovf<=0.
  - load=1: out<=min(load_val, MAX); tc<=0; ovf<=0. Values above MAX clamp to MAX.
  - en=1, up_dn=1: out<MAX -> out+1, tc<=0. out==MAX -> limit event.
  - en=1, up_dn=0: out>0 -> out-1, tc<=0. out==0 -> limit event.
  - en=0: out holds, tc<=0, ovf holds.
- Limit event:
  - SATURATE=0: wrap (up: MAX->0; down: 0->MAX); tc<=1; ovf<=1.
  - SATURATE=1: out holds at limit; tc<=1; ovf<=1. tc re-pulses every enabled cycle spent pushing against the limit.
- ovf stays 1 until clr, load or reset.
- Arithmetic: next-value computed without relying on WIDTH-bit natural wrap; MAX < 2**WIDTH-1 must wrap at MAX, not at 2**WIDTH-1.
- up_dn may change any cycle; takes effect on that edge with no dead cycle.
- Non-limit states: out never leaves 0..MAX under any input sequence after reset.

## Timing
- Single clock domain; all outputs driven directly from flops (no combinational input-to-output path).
- Latency: input sampled at edge N is reflected on out/tc/ovf after edge N.
- tc high exactly one cycle per limit event; consecutive events give consecutive high cycles.
- Simultaneous clr+load+en: clr wins. load+en: load wins, no count that cycle.
- Reset asserted mid-count: outputs go to 0 asynchronously; count does not resume from prior value.

## Test plan
- Reset: WIDTH=4, MAX=9; drive en=1 during reset low 2 cycles -> out=0, tc=0, ovf=0 throughout; after release, out=1,2,... on successive edges.
- Wrap up: SATURATE=0, en=1, up_dn=1 from 0 -> out 0..9 then 0; tc high only the cycle out shows 0 after 9; ovf=1 thereafter.
- Wrap down/saturate: SATURATE=0, down from 2 -> 1,0,9,8, tc at 9; SATURATE=1, up from 8 -> 9,9,9 with tc high for both hold cycles, ovf=1.
- Load/clamp: load=1, load_val=15 -> out=9, ovf cleared; load_val=5 with en=1 same cycle -> out=5 (no count).
- Priority: clr=1, load=1, en=1 with out=7 -> out=0, tc=0, ovf=0; en=0 for 3 cycles -> out holds.
- Async reset mid-run: at out=6, pull reset low between edges -> out=0 before next edge; release -> counting restarts from 0.
